core_mem_responder: RTL and testbench
=====================================

# core_mem_responder

Memory responder on the far side of the single-cycle core's memory interface. It answers the core's instruction fetch and its data load/store requests from one unified word-addressed array. It also owns a program-load port that fills the array after reset while holding the core in reset. It sits at the top level, between the core, the external loader (testbench or UART bridge) and the board.

## Interface
Parameters:
- DEPTH_WORDS, 1024: array depth in 32-bit words; power of two, at least 4.
- ADDR_W, $clog2(DEPTH_WORDS): word-index width.
- NOP_WORD, 32'h00000013: instruction returned while the array is not yet in RUN.

Ports (one clock; reset is synchronous and active-high):
- clk  in  1  rising-edge clock.
- rst  in  1  synchronous, active-high reset.
- pc_if  in  32  core fetch byte address.
- instruction  out  32  fetched word, combinational.
- mem_read_adr  in  32  core data read byte address.
- memory_data_output  out  32  data read word, combinational.
- mem_write_adr  in  32  core data write byte address.
- mem_write_data  in  32  core write data, already lane-aligned by the core.
- mem_we0  in  1  core store enable.
- wmask  in  4  byte-lane enables; bit i selects bits [8i+7:8i].
- load_valid  in  1  loader word valid.
- load_data  in  32  loader word.
- load_last  in  1  marks the final loader word; qualified by load_valid.
- load_ready  out  1  responder accepts a loader word.
- core_rst  out  1  reset driven to the core; high until the program is loaded.
- words_loaded  out  ADDR_W+1  count of words written by the loader since the last rst.

## Operation
- Addressing: word index = addr[ADDR_W+1:2].
  - Bits [1:0] are ignored.
  - Bits above ADDR_W+1 are ignored, so addresses wrap modulo DEPTH_WORDS*4.
- FSM has two states, LOAD and RUN.
- rst (any state) has the following effect:
  - state becomes LOAD and the load pointer becomes 0.
  - words_loaded becomes 0, core_rst becomes 1, load_ready becomes 0 for the rst cycle.
  - Array contents are NOT cleared.
- LOAD state:
  - load_ready=1.
  - A handshake (load_valid & load_ready) writes load_data to array[ptr], then increments ptr and words_loaded.
  - The FSM moves to RUN after the handshake cycle when either condition holds:
    - load_last=1 on the handshake;
    - the handshake wrote ptr=DEPTH_WORDS-1 (array full).
  - The core store port is ignored in LOAD.
  - instruction=NOP_WORD and memory_data_output=0.
- RUN state:
  - load_ready=0, core_rst=0.
  - load_valid is ignored and words_loaded is frozen.
  - instruction = array[pc_if index]; memory_data_output = array[mem_read_adr index].
  - When mem_we0=1, at the clock edge each byte lane with wmask[i]=1 of array[mem_write_adr index] takes mem_write_data lane i; other lanes keep their value.
  - mem_we0=1 with wmask=0 changes nothing.
- The array is unified: a store to the address currently being fetched is visible to the fetch from the next cycle on (self-modifying code is supported).
- Only the loader and the core store port write the array; both are never active in the same state.

## Timing
- Reads are combinational from the array; the core sees same-cycle data as its single-cycle datapath requires.
- Read during a write to the same word returns the pre-edge (old) value; the new value is visible after the edge.
- Loader writes and core stores commit on the rising clk edge.
- core_rst:
  - It is high in every cycle while in LOAD.
  - It falls in the first cycle after the final load handshake, so the core leaves reset one cycle after the last word.
  - It is registered, with no combinational path from load_valid.
- Load throughput is one word per cycle while load_valid stays high.
- Reset values:
  - state=LOAD, core_rst=1, load_ready=0 (rst cycle), words_loaded=0.
  - instruction=NOP_WORD, memory_data_output=0.
- rst asserted mid-load:
  - The partial load is abandoned and ptr restarts at 0.
  - Words already written remain in the array until overwritten.
- rst asserted mid-run: the core is put back into reset and a new load begins.
- load_last with load_valid=0 has no effect.

## Test plan
- Load path: rst 2 cycles, then stream 0x11111111, 0x22222222, 0x33333333 with load_last on the third word.
  - load_ready=1 throughout, words_loaded=3.
  - core_rst falls the cycle after the third handshake.
  - pc_if=0x8 then reads 0x33333333.
- Gaps and reads during LOAD: stream the same three words with load_valid low between them.
  - Only handshake cycles write.
  - instruction=0x00000013 and memory_data_output=0 during LOAD.
- Byte-masked store: in RUN with word 1 = 0xAABBCCDD, drive mem_we0=1, mem_write_adr=0x4, wmask=4'b0110, data=0x11223344.
  - Word 1 becomes 0xAA2233DD.
  - A same-cycle read of 0x4 returns 0xAABBCCDD; the next cycle returns 0xAA2233DD.
- Address wrap and ignored bits (DEPTH_WORDS=1024):
  - A store to 0x00001000 lands in word 0.
  - A read of 0x00000007 returns word 1.
- Full array: stream 1024 words with load_last never asserted.
  - Enters RUN after word 1023; words_loaded=1024; load_ready=0.
  - A further load_valid is ignored.
- Reset mid-operation:
  - rst after 5 of 10 loader words: words_loaded returns to 0, core_rst stays 1, old words 0–4 remain readable after the next load completes without overwriting them.
  - rst during RUN: core_rst=1 on the following cycle.

Source files
------------

// File: rtl/core_mem_responder_if.sv
// Bundle between the core_mem_responder, the single-cycle core and the program loader.
// The slave modport is the responder's view; the master modport is the core/loader view.
interface core_mem_responder_if #(
    parameter int unsigned ADDR_W = 10
) ();
    // core fetch and data ports
    logic [31:0]     pc_if;
    logic [31:0]     instruction;
    logic [31:0]     mem_read_adr;
    logic [31:0]     memory_data_output;
    logic [31:0]     mem_write_adr;
    logic [31:0]     mem_write_data;
    logic            mem_we0;
    logic [3:0]      wmask;

    // program loader stream and status
    logic            load_valid;
    logic [31:0]     load_data;
    logic            load_last;
    logic            load_ready;
    logic            core_rst;
    logic [ADDR_W:0] words_loaded;

    modport slave (
        input  pc_if,
        output instruction,
        input  mem_read_adr,
        output memory_data_output,
        input  mem_write_adr,
        input  mem_write_data,
        input  mem_we0,
        input  wmask,
        input  load_valid,
        input  load_data,
        input  load_last,
        output load_ready,
        output core_rst,
        output words_loaded
    );

    modport master (
        output pc_if,
        input  instruction,
        output mem_read_adr,
        input  memory_data_output,
        output mem_write_adr,
        output mem_write_data,
        output mem_we0,
        output wmask,
        output load_valid,
        output load_data,
        output load_last,
        input  load_ready,
        input  core_rst,
        input  words_loaded
    );
endinterface

// File: rtl/core_mem_responder.sv
// Unified instruction/data memory for the single-cycle core, with a program-load
// phase (LOAD) that fills the array and holds the core in reset before RUN.
module core_mem_responder #(
    parameter int unsigned DEPTH_WORDS = 1024,
    parameter int unsigned ADDR_W      = $clog2(DEPTH_WORDS),
    parameter logic [31:0] NOP_WORD    = 32'h0000_0013
) (
    input  logic                clk,
    input  logic                rst,
    core_mem_responder_if.slave bus
);

    localparam int unsigned DATA_W  = 32;
    localparam int unsigned LANES   = DATA_W / 8;
    localparam int unsigned CNT_W   = ADDR_W + 1;
    localparam int unsigned IDX_LSB = 2;
    localparam int unsigned IDX_MSB = ADDR_W + 1;

    typedef enum logic [0:0] {
        ST_LOAD = 1'b0,
        ST_RUN  = 1'b1
    } state_e;

    state_e state_q;
    state_e state_d;

    logic [ADDR_W-1:0] ptr_q;
    logic [ADDR_W-1:0] ptr_d;
    logic [CNT_W-1:0]  words_loaded_q;
    logic [CNT_W-1:0]  words_loaded_d;
    logic              core_rst_q;
    logic              core_rst_d;

    logic [DATA_W-1:0] mem_q [DEPTH_WORDS];

    logic              load_ready_c;
    logic              handshake_c;
    logic              last_word_c;
    logic [ADDR_W-1:0] fetch_idx_c;
    logic [ADDR_W-1:0] read_idx_c;
    logic [ADDR_W-1:0] store_idx_c;
    logic [DATA_W-1:0] instruction_c;
    logic [DATA_W-1:0] read_data_c;
    logic              wr_en_c;
    logic [ADDR_W-1:0] wr_idx_c;
    logic [DATA_W-1:0] wr_data_c;
    logic [LANES-1:0]  wr_be_c;

    // Byte addresses map to word indices; low lane bits and bits above the array wrap away.
    assign fetch_idx_c = bus.pc_if[IDX_MSB:IDX_LSB];
    assign read_idx_c  = bus.mem_read_adr[IDX_MSB:IDX_LSB];
    assign store_idx_c = bus.mem_write_adr[IDX_MSB:IDX_LSB];

    logic unused_addr_bits_c;
    assign unused_addr_bits_c = ^{bus.pc_if[DATA_W-1:IDX_MSB+1],         bus.pc_if[IDX_LSB-1:0],
                                  bus.mem_read_adr[DATA_W-1:IDX_MSB+1],  bus.mem_read_adr[IDX_LSB-1:0],
                                  bus.mem_write_adr[DATA_W-1:IDX_MSB+1], bus.mem_write_adr[IDX_LSB-1:0]};

    assign handshake_c = load_ready_c & bus.load_valid;
    assign last_word_c = bus.load_last | (ptr_q == ADDR_W'(DEPTH_WORDS - 1));

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_LOAD;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state and next loader bookkeeping
    always_comb begin
        state_d        = state_q;
        ptr_d          = ptr_q;
        words_loaded_d = words_loaded_q;

        unique case (state_q)
            ST_LOAD: begin
                if (handshake_c) begin
                    ptr_d          = ptr_q + ADDR_W'(1);
                    words_loaded_d = words_loaded_q + CNT_W'(1);
                    if (last_word_c) begin
                        state_d = ST_RUN;
                    end
                end
            end
            ST_RUN: begin
                state_d = ST_RUN;
            end
            default: begin
                state_d = ST_LOAD;
            end
        endcase

        // Core leaves reset in the cycle after the final load handshake.
        core_rst_d = (state_d == ST_LOAD);
    end

    // Outputs and array write controls
    always_comb begin
        load_ready_c  = 1'b0;
        instruction_c = NOP_WORD;
        read_data_c   = '0;
        wr_en_c       = 1'b0;
        wr_idx_c      = ptr_q;
        wr_data_c     = bus.load_data;
        wr_be_c       = '1;

        unique case (state_q)
            ST_LOAD: begin
                // Ready drops during the rst cycle so a pending word is not taken.
                load_ready_c = ~rst;
                wr_en_c      = handshake_c;
            end
            ST_RUN: begin
                instruction_c = mem_q[fetch_idx_c];
                read_data_c   = mem_q[read_idx_c];
                wr_en_c       = bus.mem_we0 & ~rst;
                wr_idx_c      = store_idx_c;
                wr_data_c     = bus.mem_write_data;
                wr_be_c       = bus.wmask;
            end
            default: begin
                load_ready_c = 1'b0;
            end
        endcase
    end

    // Loader bookkeeping and core reset
    always_ff @(posedge clk) begin
        if (rst) begin
            ptr_q          <= '0;
            words_loaded_q <= '0;
            core_rst_q     <= 1'b1;
        end else begin
            ptr_q          <= ptr_d;
            words_loaded_q <= words_loaded_d;
            core_rst_q     <= core_rst_d;
        end
    end

    // Array contents survive rst; only enabled lanes change.
    always_ff @(posedge clk) begin
        if (wr_en_c) begin
            for (int unsigned i = 0; i < LANES; i++) begin
                if (wr_be_c[i]) begin
                    mem_q[wr_idx_c][8*i +: 8] <= wr_data_c[8*i +: 8];
                end
            end
        end
    end

    assign bus.instruction        = instruction_c;
    assign bus.memory_data_output = read_data_c;
    assign bus.load_ready         = load_ready_c;
    assign bus.core_rst           = core_rst_q;
    assign bus.words_loaded       = words_loaded_q;

endmodule

// File: tb/tb_core_mem_responder.sv
// Directed vector bench for core_mem_responder: per-cycle stimulus/expectation table
// followed by a hand-written full-array load sequence.
module tb_core_mem_responder;

    localparam int unsigned DEPTH  = 1024;
    localparam int unsigned AW     = 10;
    localparam logic [31:0] NOP    = 32'h0000_0013;

    logic clk;
    logic rst;

    core_mem_responder_if #(.ADDR_W(AW)) bus_if ();

    core_mem_responder #(
        .DEPTH_WORDS(DEPTH),
        .ADDR_W     (AW),
        .NOP_WORD   (NOP)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus_if)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        r;
        logic        lv;
        logic [31:0] ld;
        logic        ll;
        logic [31:0] pc;
        logic [31:0] ra;
        logic        we;
        logic [31:0] wa;
        logic [31:0] wd;
        logic [3:0]  wm;
        logic        e_rdy;
        logic        e_crst;
        int          e_wl;
        logic [31:0] e_ins;
        logic [31:0] e_rd;
    } vec_t;

    vec_t vecs[$];
    int   n_pass;
    int   n_total;

    task automatic check(input string name, input int idx, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act !== exp) $display("FAIL %s vec %0d: got %h want %h", name, idx, act, exp);
        else n_pass++;
    endtask

    task automatic add(input logic r, input logic lv, input logic [31:0] ld, input logic ll,
                       input logic [31:0] pc, input logic [31:0] ra, input logic we,
                       input logic [31:0] wa, input logic [31:0] wd, input logic [3:0] wm,
                       input logic e_rdy, input logic e_crst, input int e_wl,
                       input logic [31:0] e_ins, input logic [31:0] e_rd);
        vec_t v;
        v.r = r; v.lv = lv; v.ld = ld; v.ll = ll; v.pc = pc; v.ra = ra;
        v.we = we; v.wa = wa; v.wd = wd; v.wm = wm;
        v.e_rdy = e_rdy; v.e_crst = e_crst; v.e_wl = e_wl; v.e_ins = e_ins; v.e_rd = e_rd;
        vecs.push_back(v);
    endtask

    // LOAD-state cycle: reads must show NOP / zero; a store attempt must be ignored.
    task automatic ld_v(input logic r, input logic lv, input logic [31:0] ld, input logic ll,
                        input logic e_rdy, input int e_wl);
        add(r, lv, ld, ll, 32'h4, 32'h4, 1'b1, 32'h0, 32'hFFFF_FFFF, 4'hF, e_rdy, 1'b1, e_wl, NOP, 32'h0);
    endtask

    // RUN-state cycle with the loader idle.
    task automatic rn_v(input logic [31:0] pc, input logic [31:0] ra, input logic we,
                        input logic [31:0] wa, input logic [31:0] wd, input logic [3:0] wm,
                        input int e_wl, input logic [31:0] e_ins, input logic [31:0] e_rd);
        add(1'b0, 1'b0, 32'h0, 1'b0, pc, ra, we, wa, wd, wm, 1'b0, 1'b0, e_wl, e_ins, e_rd);
    endtask

    task automatic drive(input vec_t v);
        rst                   = v.r;
        bus_if.load_valid     = v.lv;
        bus_if.load_data      = v.ld;
        bus_if.load_last      = v.ll;
        bus_if.pc_if          = v.pc;
        bus_if.mem_read_adr   = v.ra;
        bus_if.mem_we0        = v.we;
        bus_if.mem_write_adr  = v.wa;
        bus_if.mem_write_data = v.wd;
        bus_if.wmask          = v.wm;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        vec_t idle;
        int   bad_full;
        n_pass  = 0;
        n_total = 0;

        // Load path: three words, last on the third
        ld_v(1, 0, 32'h0, 0, 0, 0);
        ld_v(1, 0, 32'h0, 0, 0, 0);
        ld_v(0, 1, 32'h1111_1111, 0, 1, 0);
        ld_v(0, 1, 32'h2222_2222, 0, 1, 1);
        ld_v(0, 1, 32'h3333_3333, 1, 1, 2);
        rn_v(32'h8, 32'h0, 0, 0, 0, 4'h0, 3, 32'h3333_3333, 32'h1111_1111);
        add(0, 1, 32'hDEAD_BEEF, 1, 32'h4, 32'h7, 0, 0, 0, 4'h0, 0, 0, 3, 32'h2222_2222, 32'h2222_2222);
        rn_v(32'h8, 32'h8, 0, 0, 0, 4'h0, 3, 32'h3333_3333, 32'h3333_3333);
        // Reset from RUN, then a gapped load
        add(1, 0, 32'h0, 0, 32'h0, 32'h0, 0, 0, 0, 4'h0, 0, 0, 3, 32'h1111_1111, 32'h1111_1111);
        ld_v(0, 1, 32'h1234_5678, 0, 1, 0);
        ld_v(0, 0, 32'h9999_9999, 0, 1, 1);
        ld_v(0, 1, 32'hAABB_CCDD, 0, 1, 1);
        ld_v(0, 0, 32'h7777_7777, 1, 1, 2);
        ld_v(0, 1, 32'h0BAD_F00D, 1, 1, 2);
        rn_v(32'h0, 32'h4, 0, 0, 0, 4'h0, 3, 32'h1234_5678, 32'hAABB_CCDD);
        rn_v(32'h8, 32'h0, 0, 0, 0, 4'h0, 3, 32'h0BAD_F00D, 32'h1234_5678);
        // Byte-masked store: old value during the write cycle, merged value after
        rn_v(32'h4, 32'h4, 1, 32'h4, 32'h1122_3344, 4'b0110, 3, 32'hAABB_CCDD, 32'hAABB_CCDD);
        rn_v(32'h4, 32'h4, 0, 0, 0, 4'h0, 3, 32'hAA22_33DD, 32'hAA22_33DD);
        rn_v(32'h0, 32'h8, 1, 32'h8, 32'hFFFF_FFFF, 4'b0000, 3, 32'h1234_5678, 32'h0BAD_F00D);
        rn_v(32'h8, 32'h0, 1, 32'h1000, 32'hCAFE_F00D, 4'hF, 3, 32'h0BAD_F00D, 32'h1234_5678);
        rn_v(32'h0, 32'h7, 0, 0, 0, 4'h0, 3, 32'hCAFE_F00D, 32'hAA22_33DD);
        // Self-modifying store to the fetched word, low address bits ignored
        rn_v(32'h8, 32'h8, 1, 32'hB, 32'h0050_0093, 4'hF, 3, 32'h0BAD_F00D, 32'h0BAD_F00D);
        rn_v(32'h8, 32'h0, 0, 0, 0, 4'h0, 3, 32'h0050_0093, 32'hCAFE_F00D);
        rn_v(32'h0, 32'h4, 1, 32'h4, 32'h0000_00EE, 4'b0001, 3, 32'hCAFE_F00D, 32'hAA22_33DD);
        rn_v(32'h4, 32'h4, 0, 0, 0, 4'h0, 3, 32'hAA22_33EE, 32'hAA22_33EE);
        // Reset during RUN, then reset mid-load after five words
        add(1, 0, 32'h0, 0, 32'h0, 32'h0, 0, 0, 0, 4'h0, 0, 0, 3, 32'hCAFE_F00D, 32'hCAFE_F00D);
        for (int i = 0; i < 5; i++) ld_v(0, 1, 32'h5000_0000 + 32'(i), 0, 1, i);
        ld_v(1, 1, 32'h5A5A_5A5A, 0, 0, 5);
        ld_v(0, 0, 32'h0, 0, 1, 0);
        ld_v(0, 1, 32'h600D_0000, 1, 1, 0);
        rn_v(32'h0, 32'h4, 0, 0, 0, 4'h0, 1, 32'h600D_0000, 32'h5000_0001);
        rn_v(32'h10, 32'hC, 0, 0, 0, 4'h0, 1, 32'h5000_0004, 32'h5000_0003);
        rn_v(32'h8, 32'h0, 0, 0, 0, 4'h0, 1, 32'h5000_0002, 32'h600D_0000);

        idle = vecs[0];
        drive(idle);
        @(posedge clk); #1;

        for (int i = 0; i < vecs.size(); i++) begin
            drive(vecs[i]);
            @(negedge clk);
            check("load_ready", i, 32'(bus_if.load_ready), 32'(vecs[i].e_rdy));
            check("core_rst", i, 32'(bus_if.core_rst), 32'(vecs[i].e_crst));
            check("words_loaded", i, 32'(bus_if.words_loaded), 32'(vecs[i].e_wl));
            check("instruction", i, bus_if.instruction, vecs[i].e_ins);
            check("read_data", i, bus_if.memory_data_output, vecs[i].e_rd);
            @(posedge clk); #1;
        end

        // Full array: 1024 words without load_last
        idle.r = 1'b1; idle.lv = 1'b0; idle.we = 1'b0;
        drive(idle);
        @(posedge clk); #1;
        rst = 1'b0;
        bad_full = 0;
        for (int i = 0; i < int'(DEPTH); i++) begin
            bus_if.load_valid = 1'b1;
            bus_if.load_data  = 32'hA500_0000 | 32'(i);
            bus_if.load_last  = 1'b0;
            @(negedge clk);
            if (bus_if.load_ready !== 1'b1 || bus_if.core_rst !== 1'b1) bad_full++;
            if (i == int'(DEPTH) - 1) check("full_wl_pre", i, 32'(bus_if.words_loaded), 32'd1023);
            @(posedge clk); #1;
        end
        check("full_stream", 0, 32'(bad_full), 32'd0);
        bus_if.load_data = 32'h0BAD_0BAD;
        bus_if.pc_if = 32'hFFC;
        bus_if.mem_read_adr = 32'h1000;
        @(negedge clk);
        check("full_ready", 1, 32'(bus_if.load_ready), 32'd0);
        check("full_crst", 1, 32'(bus_if.core_rst), 32'd0);
        check("full_wl", 1, 32'(bus_if.words_loaded), 32'd1024);
        check("full_ins", 1, bus_if.instruction, 32'hA500_03FF);
        check("full_rd", 1, bus_if.memory_data_output, 32'hA500_0000);
        @(posedge clk); #1;
        bus_if.load_valid = 1'b0;
        bus_if.mem_read_adr = 32'h0;
        @(negedge clk);
        check("full_ignored_wl", 2, 32'(bus_if.words_loaded), 32'd1024);
        check("full_ignored_rd", 2, bus_if.memory_data_output, 32'hA500_0000);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
